// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared definitions for the octal register bus arbiter:
//               sequencer state encoding, parameter limits and clog2 helper.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    // Legal parameter ranges
    localparam int NREQ_MIN         = 2;
    localparam int NREQ_MAX         = 8;
    localparam int DRIVE_CYCLES_MIN = 1;
    localparam int DRIVE_CYCLES_MAX = 15;

    // Ceiling log2, used to size index and counter fields
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit found searching upward from ptr, wrapping at
//               NREQ-1 back to 0, and whether any request is set at all.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] win,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    // Rotate the request vector so that bit 0 corresponds to ptr
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NREQ-1:0];

    // Priority search of the rotated vector, then map back to a real index
    always_comb begin
        int s;
        win = '0;
        any = 1'b0;
        s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                s   = int'(ptr) + k;
                if (s >= NREQ) begin
                    s = s - NREQ;
                end
                win = IDXW'(s);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/octal_bus_arbiter.sv
// ============================================================================
// Module      : octal_bus_arbiter
// Description : Round-robin sequencer sharing one 8-bit tristate bus among
//               NREQ octal D registers. Issues a one-cycle load strobe, drives
//               the owner's output enable for DRIVE_CYCLES cycles, then
//               inserts one dead turnaround cycle. At most one output enable
//               is ever low. All outputs are registered and cleared
//               asynchronously by reset.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module octal_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DRIVE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] load,
    output logic [NREQ-1:0] oenb_n,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            xfer_done
);

    localparam int             IDXW     = clog2(NREQ);
    localparam int             CNTW     = clog2(DRIVE_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(DRIVE_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

    logic [1:0]      state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [IDXW-1:0] win, win_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;

    logic [IDXW-1:0] pick_win;
    logic            pick_any;

    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] load_nxt;
    logic [NREQ-1:0] oenb_n_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            busy_nxt;
    logic            xfer_done_nxt;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .any (pick_any)
    );

    // Next-state logic: arbitration in IDLE, fixed-length transfer afterwards
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    win_nxt   = pick_win;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_nxt   = CNT_INIT;
                state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                // Counter holds at zero on exit so it can never wrap
                if (cnt == '0) begin
                    state_nxt = ST_TURN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_TURN: begin
                ptr_nxt   = (win == IDX_LAST) ? '0 : win + 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so registered outputs line up
    // with the state they describe
    always_comb begin
        owner_oh      = NREQ'(1) << win_nxt;
        load_nxt      = '0;
        oenb_n_nxt    = '1;
        gnt_nxt       = '0;
        xfer_done_nxt = 1'b0;
        busy_nxt      = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_LOAD: begin
                load_nxt = owner_oh;
                gnt_nxt  = owner_oh;
            end
            ST_DRIVE: begin
                oenb_n_nxt    = ~owner_oh;
                gnt_nxt       = owner_oh;
                xfer_done_nxt = (cnt_nxt == '0);
            end
            default: begin
            end
        endcase
    end

    // State, pointer, winner and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output registers; reset releases the bus without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load      <= '0;
            oenb_n    <= '1;
            gnt       <= '0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            load      <= load_nxt;
            oenb_n    <= oenb_n_nxt;
            gnt       <= gnt_nxt;
            busy      <= busy_nxt;
            xfer_done <= xfer_done_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_octal_bus_arbiter.sv
// ============================================================================
// Module      : tb_octal_bus_arbiter
// Description : Directed self-checking bench for octal_bus_arbiter, with one
//               instance at DRIVE_CYCLES=2 and one at DRIVE_CYCLES=1.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_octal_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] load;
    logic [3:0] oenb_n;
    logic [3:0] gnt;
    logic       busy;
    logic       xfer_done;

    logic       reset1;
    logic [3:0] req1;
    logic [3:0] load1;
    logic [3:0] oenb_n1;
    logic [3:0] gnt1;
    logic       busy1;
    logic       xfer_done1;

    int n_checks;
    int n_fail;

    octal_bus_arbiter #(
        .NREQ         (4),
        .DRIVE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .load      (load),
        .oenb_n    (oenb_n),
        .gnt       (gnt),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    octal_bus_arbiter #(
        .NREQ         (4),
        .DRIVE_CYCLES (1)
    ) dut1 (
        .clk       (clk),
        .reset     (reset1),
        .req       (req1),
        .load      (load1),
        .oenb_n    (oenb_n1),
        .gnt       (gnt1),
        .busy      (busy1),
        .xfer_done (xfer_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        n_checks++;
        if ({load, oenb_n, gnt, busy, xfer_done} !== {4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: load=%b oenb_n=%b gnt=%b busy=%b xfer_done=%b, required 0000 1111 0000 0 0",
                     load, oenb_n, gnt, busy, xfer_done);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        n_checks++;
        if ({load, gnt, oenb_n, busy} !== {4'b0001, 4'b0001, 4'b1111, 1'b1}) begin
            n_fail++;
            $display("FAIL single_load: load=%b gnt=%b oenb_n=%b busy=%b, required 0001 0001 1111 1", load, gnt, oenb_n, busy);
        end
        tick();
        n_checks++;
        if ({load, oenb_n, gnt, xfer_done} !== {4'b0000, 4'b1110, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL single_drive1: load=%b oenb_n=%b gnt=%b xfer_done=%b, required 0000 1110 0001 0", load, oenb_n, gnt, xfer_done);
        end
        tick();
        n_checks++;
        if ({oenb_n, gnt, xfer_done} !== {4'b1110, 4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL single_drive2: oenb_n=%b gnt=%b xfer_done=%b, required 1110 0001 1", oenb_n, gnt, xfer_done);
        end
        tick();
        n_checks++;
        if ({oenb_n, gnt, busy, xfer_done} !== {4'b1111, 4'b0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_turn: oenb_n=%b gnt=%b busy=%b xfer_done=%b, required 1111 0000 1 0", oenb_n, gnt, busy, xfer_done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req   = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            logic [3:0] exp;
            exp = 4'b0001 << (n % 4);
            for (int c = 0; c < 5; c++) begin
                tick();
                n_checks++;
                if ($countones(~oenb_n) > 1) begin
                    n_fail++;
                    $display("FAIL rr_exclusive: transfer %0d cycle %0d oenb_n=%b, required at most one low", n, c, oenb_n);
                end
                n_checks++;
                if (c == 0 && {load, gnt, oenb_n} !== {exp, exp, 4'b1111}) begin
                    n_fail++;
                    $display("FAIL rr_load: transfer %0d load=%b gnt=%b oenb_n=%b, required %b %b 1111", n, load, gnt, oenb_n, exp, exp);
                end else if ((c == 1 || c == 2) && {oenb_n, gnt, load} !== {~exp, exp, 4'b0000}) begin
                    n_fail++;
                    $display("FAIL rr_drive: transfer %0d cycle %0d oenb_n=%b gnt=%b load=%b, required %b %b 0000", n, c, oenb_n, gnt, load, ~exp, exp);
                end else if (c == 3 && {oenb_n, gnt} !== {4'b1111, 4'b0000}) begin
                    n_fail++;
                    $display("FAIL rr_turn: transfer %0d oenb_n=%b gnt=%b, required 1111 0000", n, oenb_n, gnt);
                end else if (c == 4 && busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_idle: transfer %0d busy=%b, required 0", n, busy);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        // Pointer is 0 here; serving requester 2 leaves it at 3
        req = 4'b0100;
        tick();
        n_checks++;
        if (load !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_first: load=%b, required 0100", load);
        end
        req = 4'b1001;
        repeat (4) tick();
        tick();
        n_checks++;
        if (load !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_ptr3: load=%b, required 1000", load);
        end
        repeat (4) tick();
        tick();
        n_checks++;
        if (load !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_to0: load=%b, required 0001", load);
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_drop_req();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        n_checks++;
        if (oenb_n !== 4'b1101) begin
            n_fail++;
            $display("FAIL drop_drive1: oenb_n=%b, required 1101", oenb_n);
        end
        tick();
        n_checks++;
        if ({oenb_n, gnt, xfer_done} !== {4'b1101, 4'b0010, 1'b1}) begin
            n_fail++;
            $display("FAIL drop_drive2: oenb_n=%b gnt=%b xfer_done=%b, required 1101 0010 1", oenb_n, gnt, xfer_done);
        end
        tick();
        n_checks++;
        if ({oenb_n, xfer_done} !== {4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_turn: oenb_n=%b xfer_done=%b, required 1111 0", oenb_n, xfer_done);
        end
        tick();
    endtask

    task automatic test_reset_mid_drive();
        // Pointer is 2 here, so requester 3 wins
        req = 4'b1000;
        tick();
        tick();
        n_checks++;
        if (oenb_n !== 4'b0111) begin
            n_fail++;
            $display("FAIL rst_pre_drive: oenb_n=%b, required 0111", oenb_n);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({oenb_n, load, gnt, busy, xfer_done} !== {4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_async: oenb_n=%b load=%b gnt=%b busy=%b xfer_done=%b, required 1111 0000 0000 0 0",
                     oenb_n, load, gnt, busy, xfer_done);
        end
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        n_checks++;
        if (load !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_next_grant: load=%b, required 0001", load);
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_drive_one();
        reset1 = 1'b0;
        req1   = 4'b0100;
        tick();
        n_checks++;
        if ({load1, gnt1, oenb_n1} !== {4'b0100, 4'b0100, 4'b1111}) begin
            n_fail++;
            $display("FAIL d1_load: load=%b gnt=%b oenb_n=%b, required 0100 0100 1111", load1, gnt1, oenb_n1);
        end
        tick();
        n_checks++;
        if ({oenb_n1, xfer_done1, load1} !== {4'b1011, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL d1_drive: oenb_n=%b xfer_done=%b load=%b, required 1011 1 0000", oenb_n1, xfer_done1, load1);
        end
        tick();
        n_checks++;
        if ({oenb_n1, gnt1, xfer_done1, busy1} !== {4'b1111, 4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL d1_turn: oenb_n=%b gnt=%b xfer_done=%b busy=%b, required 1111 0000 0 1", oenb_n1, gnt1, xfer_done1, busy1);
        end
        tick();
        n_checks++;
        if ({busy1, load1} !== {1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL d1_idle: busy=%b load=%b, required 0 0000", busy1, load1);
        end
        tick();
        n_checks++;
        if (load1 !== 4'b0100) begin
            n_fail++;
            $display("FAIL d1_period: load=%b, required 0100 four cycles after previous load", load1);
        end
        req1 = 4'b0000;
        repeat (3) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset1   = 1'b1;
        req1     = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drop_req();
        test_reset_mid_drive();
        test_drive_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
